// File: rtl/fifo_uart_pkg.sv
// Shared constants for the FIFO-draining UART transmitter: state encoding, data width, frame length.
// FRAME_BITS follows the FIFO_UART_TX_PARITY_EN build option.
package fifo_uart_pkg;

    localparam int DATA_W    = 8;
    localparam int BIT_CNT_W = 3;

    localparam int FRAME_BITS_NO_PARITY = 10;
    localparam int FRAME_BITS_PARITY    = 11;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int FRAME_BITS = FRAME_BITS_PARITY;
`else
    localparam int FRAME_BITS = FRAME_BITS_NO_PARITY;
`endif

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_FETCH  = 3'd1;
    localparam state_t ST_LOAD   = 3'd2;
    localparam state_t ST_START  = 3'd3;
    localparam state_t ST_DATA   = 3'd4;
    localparam state_t ST_PARITY = 3'd5;
    localparam state_t ST_STOP   = 3'd6;

    localparam logic [BIT_CNT_W-1:0] LAST_DATA_BIT = BIT_CNT_W'(DATA_W - 1);

endpackage

// File: rtl/fifo_uart_tx_baud.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// Shared between transmit and a future receive path.
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        if (clr || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from a synchronous FIFO and sends each as an 8N1 serial frame on tx.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit (8E1).
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              re,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    state_t                state_q, state_d;
    logic [DATA_W-1:0]     shift_q, shift_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic                  tx_q, tx_d;
    logic                  tick;
    logic                  clr_baud;
`ifdef FIFO_UART_TX_PARITY_EN
    logic                  parity_q, parity_d;
`endif

    // Every state change restarts the bit period; inside DATA the counter wraps by itself.
    assign clr_baud = (state_d != state_q);

    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (clr_baud),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (enable && !empty) state_d = ST_FETCH;
            end
            ST_FETCH: state_d = ST_LOAD;
            ST_LOAD: begin
                shift_d = fifo_data;
`ifdef FIFO_UART_TX_PARITY_EN
                parity_d = ^fifo_data;
`endif
                state_d = ST_START;
            end
            ST_START: begin
                if (tick) begin
                    bit_cnt_d = '0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    if (bit_cnt_q == LAST_DATA_BIT) begin
`ifdef FIFO_UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            ST_PARITY: begin
                if (tick) state_d = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (tick) state_d = (enable && !empty) ? ST_FETCH : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // tx is registered from the next state so the line changes on the same edge as the state.
    always_comb begin
        re   = (state_q == ST_FETCH);
        busy = (state_q != ST_IDLE);
        done = (state_q == ST_STOP) && tick;
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
`ifdef FIFO_UART_TX_PARITY_EN
            ST_PARITY: tx_d = parity_d;
`endif
            default:   tx_d = 1'b1;
        endcase
    end

    assign tx = tx_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx with CLKS_PER_BIT=4, a behavioural FIFO and a frame-level line model.
// Build with FIFO_UART_TX_PARITY_EN defined to also exercise the parity frame.
module tb_fifo_uart_tx;

    localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYC = FRAME_BITS * CPB;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       empty;
    logic [7:0] fifo_data;
    logic       re, tx, busy, done;

    logic [7:0] mem [0:255];
    logic [7:0] fifo_rdata;
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic       ovr = 1'b0;
    logic       ovr_empty = 1'b1;
    logic [7:0] ovr_data = 8'h00;

    int n_checks = 0;
    int n_fail   = 0;

    logic       tx_log[$];
    logic       re_log[$];
    logic       done_log[$];
    logic       busy_log[$];
    bit         rec_en = 1'b0;
    logic [7:0] tx_bytes[$];
    logic       exp_q[$];

    fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .empty    (empty),
        .fifo_data(fifo_data),
        .re       (re),
        .tx       (tx),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Behavioural synchronous FIFO: registered read data, one pop per re cycle.
    assign empty     = ovr ? ovr_empty : (wr_ptr == rd_ptr);
    assign fifo_data = ovr ? ovr_data : fifo_rdata;
    always @(posedge clk) begin
        if (re === 1'b1) begin
            fifo_rdata <= mem[rd_ptr[7:0]];
            rd_ptr     <= rd_ptr + 1;
        end
    end

    always @(negedge clk) begin
        if (rec_en) begin
            tx_log.push_back(tx);
            re_log.push_back(re);
            done_log.push_back(done);
            busy_log.push_back(busy);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr[7:0]] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic start_log();
        tx_log.delete();
        re_log.delete();
        done_log.delete();
        busy_log.delete();
        rec_en = 1'b1;
    endtask

    // Expected line level per cycle for the bytes in tx_bytes, sent back to back.
    function automatic void build_expect();
        logic [7:0] b;
        logic       lvl;
        exp_q.delete();
        for (int k = 0; k < tx_bytes.size(); k++) begin
            b = tx_bytes[k];
            if (k > 0) begin
                exp_q.push_back(1'b1);
                exp_q.push_back(1'b1);
            end
            for (int bit_i = 0; bit_i < FRAME_BITS; bit_i++) begin
                if (bit_i == 0) lvl = 1'b0;
                else if (bit_i <= 8) lvl = b[bit_i-1];
                else if (bit_i == 9 && FRAME_BITS == 11) lvl = ^b;
                else lvl = 1'b1;
                for (int c = 0; c < CPB; c++) exp_q.push_back(lvl);
            end
        end
    endfunction

    function automatic int first_low(input int from);
        for (int i = from; i < tx_log.size(); i++) if (tx_log[i] === 1'b0) return i;
        return -1;
    endfunction

    function automatic int count_re();
        int n = 0;
        foreach (re_log[i]) if (re_log[i] !== 1'b0) n++;
        return n;
    endfunction

    function automatic int first_re();
        foreach (re_log[i]) if (re_log[i] === 1'b1) return i;
        return -1;
    endfunction

    function automatic int count_done();
        int n = 0;
        foreach (done_log[i]) if (done_log[i] !== 1'b0) n++;
        return n;
    endfunction

    function automatic int first_done();
        foreach (done_log[i]) if (done_log[i] === 1'b1) return i;
        return -1;
    endfunction

    function automatic int stream_errors(input int t0);
        int e = 0;
        foreach (exp_q[i]) begin
            if (t0 + i >= tx_log.size()) e++;
            else if (tx_log[t0+i] !== exp_q[i]) e++;
        end
        return e;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        ovr   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            enable    = 1'($urandom);
            ovr_empty = 1'($urandom);
            ovr_data  = 8'($urandom);
            #1;
            n_checks++;
            if ({tx, re, busy, done} !== 4'b1000) begin
                n_fail++;
                $display("FAIL reset_hold cyc %0d: tx/re/busy/done=%b required 1000", i, {tx, re, busy, done});
            end
        end
        $display("reset held 20 cycles with random inputs");
        ovr    = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cycles(2);
    endtask

    task automatic test_single_byte();
        int t0, ri, e;
        start_log();
        tx_bytes = '{8'hA5};
        build_expect();
        push(8'hA5);
        enable = 1'b1;
        cycles(FRAME_CYC + 20);
        rec_en = 1'b0;
        t0 = first_low(0);
        ri = first_re();
        $display("single byte 0xa5: re at %0d, start bit at %0d", ri, t0);
        n_checks++;
        if (count_re() !== 1) begin
            n_fail++; $display("FAIL single_re_count got %0d required 1", count_re());
        end
        n_checks++;
        if (t0 !== ri + 2 || ri < 0) begin
            n_fail++; $display("FAIL single_latency start bit at %0d required %0d", t0, ri + 2);
        end
        n_checks++;
        e = (t0 < 0) ? exp_q.size() : stream_errors(t0);
        if (e !== 0) begin
            n_fail++; $display("FAIL single_frame %0d wrong tx cycles required 0", e);
        end
        n_checks++;
        if (count_done() !== 1 || first_done() !== t0 + FRAME_CYC - 1) begin
            n_fail++;
            $display("FAIL single_done count %0d at %0d required 1 at %0d", count_done(), first_done(), t0 + FRAME_CYC - 1);
        end
        n_checks++;
        if (busy_log[busy_log.size()-1] !== 1'b0 || tx_log[tx_log.size()-1] !== 1'b1) begin
            n_fail++; $display("FAIL single_idle busy=%b tx=%b required busy=0 tx=1",
                               busy_log[busy_log.size()-1], tx_log[tx_log.size()-1]);
        end
    endtask

    task automatic test_back_to_back();
        int t0, t1, e;
        start_log();
        tx_bytes = '{8'h00, 8'hFF};
        build_expect();
        push(8'h00);
        push(8'hFF);
        enable = 1'b1;
        cycles(2 * FRAME_CYC + 24);
        rec_en = 1'b0;
        t0 = first_low(0);
        t1 = (t0 < 0) ? -1 : first_low(t0 + FRAME_CYC);
        $display("back-to-back 0x00,0xff: starts at %0d and %0d", t0, t1);
        n_checks++;
        if (count_re() !== 2) begin
            n_fail++; $display("FAIL b2b_re_count got %0d required 2", count_re());
        end
        n_checks++;
        if (t0 < 0 || t1 - (t0 + FRAME_CYC) !== 2) begin
            n_fail++; $display("FAIL b2b_gap got %0d high cycles required 2", t1 - (t0 + FRAME_CYC));
        end
        n_checks++;
        e = (t0 < 0) ? exp_q.size() : stream_errors(t0);
        if (e !== 0) begin
            n_fail++; $display("FAIL b2b_stream %0d wrong tx cycles required 0", e);
        end
        n_checks++;
        if (count_done() !== 2) begin
            n_fail++; $display("FAIL b2b_done_count got %0d required 2", count_done());
        end
        n_checks++;
        if (busy_log[busy_log.size()-1] !== 1'b0 || tx_log[tx_log.size()-1] !== 1'b1) begin
            n_fail++; $display("FAIL b2b_idle busy=%b tx=%b required busy=0 tx=1",
                               busy_log[busy_log.size()-1], tx_log[tx_log.size()-1]);
        end
    endtask

    task automatic test_starvation();
        int lows = 0;
        start_log();
        enable = 1'b1;
        cycles(200);
        rec_en = 1'b0;
        foreach (tx_log[i]) if (tx_log[i] !== 1'b1) lows++;
        $display("starvation: 200 cycles with empty fifo");
        n_checks++;
        if (count_re() !== 0) begin
            n_fail++; $display("FAIL starve_re got %0d re cycles required 0", count_re());
        end
        n_checks++;
        if (lows !== 0) begin
            n_fail++; $display("FAIL starve_tx got %0d non-high cycles required 0", lows);
        end
    endtask

    task automatic test_random();
        int n, t0, e;
        start_log();
        n = 3 + int'($urandom_range(0, 2));
        tx_bytes.delete();
        for (int i = 0; i < n; i++) begin
            tx_bytes.push_back(8'($urandom));
            push(tx_bytes[i]);
            $display("random byte %0d: 0x%02h", i, tx_bytes[i]);
        end
        build_expect();
        enable = 1'b1;
        cycles(n * (FRAME_CYC + 2) + 20);
        rec_en = 1'b0;
        t0 = first_low(0);
        n_checks++;
        if (count_re() !== n) begin
            n_fail++; $display("FAIL rand_re_count got %0d required %0d", count_re(), n);
        end
        n_checks++;
        e = (t0 < 0) ? exp_q.size() : stream_errors(t0);
        if (e !== 0) begin
            n_fail++; $display("FAIL rand_stream %0d wrong tx cycles required 0", e);
        end
        n_checks++;
        if (count_done() !== n) begin
            n_fail++; $display("FAIL rand_done_count got %0d required %0d", count_done(), n);
        end
    endtask

    task automatic test_enable_drop();
        int t0, e, w, lows;
        start_log();
        tx_bytes = '{8'h3C};
        build_expect();
        push(8'h3C);
        push(8'h55);
        enable = 1'b1;
        w = 0;
        while (tx !== 1'b0 && w < 20) begin
            @(negedge clk);
            w++;
        end
        n_checks++;
        if (tx !== 1'b0) begin
            n_fail++; $display("FAIL drop_start tx=%b after %0d cycles required 0", tx, w);
        end
        cycles(17);
        enable = 1'b0;
        cycles(FRAME_CYC + 20);
        rec_en = 1'b0;
        t0 = first_low(0);
        $display("enable drop during 0x3c: start bit at %0d", t0);
        n_checks++;
        if (count_re() !== 1) begin
            n_fail++; $display("FAIL drop_re_count got %0d required 1", count_re());
        end
        n_checks++;
        e = (t0 < 0) ? exp_q.size() : stream_errors(t0);
        if (e !== 0) begin
            n_fail++; $display("FAIL drop_frame %0d wrong tx cycles required 0", e);
        end
        lows = 0;
        for (int i = t0 + FRAME_CYC; i < tx_log.size(); i++) if (tx_log[i] !== 1'b1) lows++;
        n_checks++;
        if (t0 < 0 || lows !== 0 || busy_log[busy_log.size()-1] !== 1'b0) begin
            n_fail++; $display("FAIL drop_idle %0d low cycles busy=%b required 0 and busy=0",
                               lows, busy_log[busy_log.size()-1]);
        end
    endtask

    task automatic test_reset_mid_frame();
        int w, t0, e;
        logic [7:0] pend;
        pend = 8'h55;
        enable = 1'b1;
        w = 0;
        while (tx !== 1'b0 && w < 20) begin
            @(negedge clk);
            w++;
        end
        cycles(25);
        n_checks++;
        if (tx !== pend[5]) begin
            n_fail++; $display("FAIL rstmid_bit5 tx=%b required %b", tx, pend[5]);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({tx, re, busy} !== 3'b100) begin
            n_fail++; $display("FAIL rstmid_async tx/re/busy=%b required 100", {tx, re, busy});
        end
        $display("reset asserted during data bit 5 of 0x55");
        cycles(3);
        rst_n = 1'b1;
        cycles(2);
        start_log();
        tx_bytes = '{8'h96};
        build_expect();
        push(8'h96);
        cycles(FRAME_CYC + 20);
        rec_en = 1'b0;
        t0 = first_low(0);
        $display("post-reset byte 0x96: start bit at %0d", t0);
        n_checks++;
        if (count_re() !== 1) begin
            n_fail++; $display("FAIL rstmid_re_count got %0d required 1", count_re());
        end
        n_checks++;
        e = (t0 < 0) ? exp_q.size() : stream_errors(t0);
        if (e !== 0 || count_done() !== 1) begin
            n_fail++; $display("FAIL rstmid_frame %0d wrong tx cycles, %0d done required 0 and 1", e, count_done());
        end
    endtask

`ifdef FIFO_UART_TX_PARITY_EN
    task automatic test_parity();
        int t0;
        logic [7:0] vals [2];
        logic       par_exp [2];
        vals[0] = 8'h07; par_exp[0] = 1'b1;
        vals[1] = 8'h03; par_exp[1] = 1'b0;
        enable = 1'b1;
        for (int k = 0; k < 2; k++) begin
            start_log();
            push(vals[k]);
            cycles(FRAME_CYC + 20);
            rec_en = 1'b0;
            t0 = first_low(0);
            $display("parity byte 0x%02h: start bit at %0d", vals[k], t0);
            n_checks++;
            if (t0 < 0 || tx_log[t0 + 37] !== par_exp[k]) begin
                n_fail++; $display("FAIL parity_bit byte 0x%02h got %b required %b",
                                   vals[k], (t0 < 0) ? 1'bx : tx_log[t0 + 37], par_exp[k]);
            end
            n_checks++;
            if (first_done() !== t0 + 43) begin
                n_fail++; $display("FAIL parity_len done at %0d required %0d", first_done(), t0 + 43);
            end
        end
    endtask
`endif

    initial begin
        rst_n  = 1'b0;
        enable = 1'b0;
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_starvation();
        test_random();
        test_enable_drop();
        test_reset_mid_frame();
`ifdef FIFO_UART_TX_PARITY_EN
        test_parity();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
